rr_arb4_ctrl: RTL and testbench

//  4-requester round-robin arbiter sharing one resource whose select path is a 2-to-4 enabled decoder.

---
 rtl/arb_pkg.sv | 29 ++
 rtl/rr_arb4_ctrl_d2to4.sv | 16 +
 rtl/rr_arb4_ctrl.sv | 106 ++++++++++
 tb/tb_rr_arb4_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
package arb_pkg;

    localparam int NREQ = 4;
    localparam int IDXW = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Rotating-priority search: scans last+1, last+2, ... (wrapping) and
    // returns {found, index} of the first set bit in mask. The loop runs
    // from the farthest position down so the nearest hit is written last.
    function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] mask,
                                              input logic [IDXW-1:0] last);
        logic [IDXW-1:0] pos;
        logic [IDXW:0]   result;
        result = '0;
        for (int k = NREQ; k >= 1; k--) begin
            pos = last + IDXW'(k);
            if (mask[pos]) begin
                result = {1'b1, pos};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arb4_ctrl_d2to4.sv
// 2-to-4 enabled decoder: one-hot output for sel when en=1, zero otherwise.
module d2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    // Decode the selected index into a one-hot word, gated by enable.
    always_comb begin
        y = 4'b0000;
        if (en) begin
            y = 4'b0001 << sel;
        end
    end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Round-robin arbiter for four requesters with a bounded hold time.
// The owner keeps the grant until it drops its request, the enable goes
// low, or it has held for MAX_HOLD cycles while someone else is waiting.
module rr_arb4_ctrl
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [3:0]      req,
    output logic [3:0]      gnt,
    output logic            gnt_valid,
    output logic [1:0]      gnt_idx,
    output logic [CW-1:0]   hold_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   idx_nxt;
    logic [CW-1:0]     cnt_nxt;
    logic              grant_nxt;
    logic [NREQ-1:0]   gnt_nxt;

    logic [NREQ-1:0]   owner_oh;
    logic [NREQ-1:0]   others;
    logic [IDXW:0]     pick_all;
    logic [IDXW:0]     pick_oth;
    logic              hold_limit;

    // Candidate winners: over all requests, and over everyone but the owner.
    always_comb begin
        owner_oh   = NREQ'(1) << gnt_idx;
        others     = req & ~owner_oh;
        pick_all   = rr_pick(req, gnt_idx);
        pick_oth   = rr_pick(others, gnt_idx);
        hold_limit = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD - 1));
    end

    // Next-state, next-owner and hold counter selection.
    always_comb begin
        state_nxt = state;
        idx_nxt   = gnt_idx;
        cnt_nxt   = hold_cnt;
        case (state)
            IDLE: begin
                if (en && pick_all[IDXW]) begin
                    state_nxt = BUSY;
                    idx_nxt   = pick_all[IDXW-1:0];
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!req[gnt_idx]) begin
                    // Owner released: hand straight over, no idle bubble.
                    cnt_nxt = '0;
                    if (pick_all[IDXW]) begin
                        idx_nxt = pick_all[IDXW-1:0];
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (hold_limit && (others != '0)) begin
                    // Hold budget spent with others waiting: preempt.
                    idx_nxt = pick_oth[IDXW-1:0];
                    cnt_nxt = '0;
                end else if (hold_cnt != '1) begin
                    cnt_nxt = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign grant_nxt = (state_nxt == BUSY);

    d2to4 u_dec (
        .sel (idx_nxt),
        .en  (grant_nxt),
        .y   (gnt_nxt)
    );

    // State, owner pointer, hold counter and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '1;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= grant_nxt;
            gnt_idx   <= idx_nxt;
            hold_cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Self-checking bench for rr_arb4_ctrl: directed scenarios plus random
// request traffic compared against a behavioural arbitration model.
module tb_rr_arb4_ctrl;

    localparam int MAX_HOLD = 8;
    localparam int CW       = 4;
    localparam int CNT_SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic [3:0]    req = 4'b0000;
    logic [3:0]    gnt;
    logic          gnt_valid;
    logic [1:0]    gnt_idx;
    logic [CW-1:0] hold_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: who owns the resource and for how long.
    bit m_busy;
    int m_owner;
    int m_held;

    rr_arb4_ctrl #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First requester after 'last' walking upward around the ring; -1 if none.
    function automatic int next_in_ring(input logic [3:0] mask, input int last);
        for (int step = 1; step <= 4; step++) begin
            if (mask[(last + step) % 4]) return (last + step) % 4;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 3;
        m_held  = 0;
    endfunction

    function automatic void model_step(input logic e, input logic [3:0] r);
        int w;
        logic [3:0] rest;
        if (!e) begin
            m_busy = 1'b0;
            m_held = 0;
        end else if (!m_busy) begin
            w = next_in_ring(r, m_owner);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_held  = 0;
            end
        end else if (!r[m_owner]) begin
            w = next_in_ring(r, m_owner);
            m_held = 0;
            if (w >= 0) m_owner = w;
            else        m_busy = 1'b0;
        end else begin
            rest = r;
            rest[m_owner] = 1'b0;
            if (MAX_HOLD != 0 && m_held == MAX_HOLD - 1 && rest != 0) begin
                m_owner = next_in_ring(rest, m_owner);
                m_held  = 0;
            end else if (m_held < CNT_SAT) begin
                m_held++;
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        logic [3:0] exp_gnt;
        exp_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        check({tag, ".gnt"},       gnt,       exp_gnt);
        check({tag, ".gnt_valid"}, gnt_valid, m_busy);
        check({tag, ".gnt_idx"},   gnt_idx,   m_owner);
        check({tag, ".hold_cnt"},  hold_cnt,  m_held);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step(en, req);
        @(negedge clk);
        compare_model(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst.gnt",       gnt,       4'b0000);
        check("rst.gnt_valid", gnt_valid, 1'b0);
        check("rst.gnt_idx",   gnt_idx,   2'd3);
        check("rst.hold_cnt",  hold_cnt,  0);
        model_reset();
        #4 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] order [5];
        int run;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        do_reset();

        // All request; each owner drops after one cycle -> 0,1,2,3,0.
        en  = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick("rr_order");
            check("rr_order.seq", gnt, order[i]);
            req = ~gnt;
        end

        // Sole requester is never preempted; counter saturates.
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        for (int i = 0; i < 20; i++) tick("sole");
        check("sole.gnt", gnt, 4'b0100);
        check("sole.sat", hold_cnt, CNT_SAT);

        // Bounded hold: requester 0 keeps asking, requester 2 arrives later.
        do_reset();
        en  = 1'b1;
        req = 4'b0001;
        tick("hold");
        tick("hold");
        tick("hold");
        req = 4'b0101;
        run = 3;
        while (gnt == 4'b0001 && run < 40) begin
            tick("hold");
            if (gnt == 4'b0001) run++;
        end
        check("hold.cycles", run, MAX_HOLD);
        check("hold.next", gnt, 4'b0100);

        // Owner 1 releases while 3 waits: back-to-back handover.
        do_reset();
        en  = 1'b1;
        req = 4'b0010;
        tick("b2b");
        req = 4'b1010;
        tick("b2b");
        check("b2b.owner1", gnt, 4'b0010);
        req = 4'b1000;
        tick("b2b");
        check("b2b.owner3", gnt, 4'b1000);

        // Enable drop releases grant, pointer kept; resumes after owner 2.
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        tick("en");
        en = 1'b0;
        tick("en");
        check("en_off.gnt", gnt, 4'b0000);
        check("en_off.idx", gnt_idx, 2'd2);
        en  = 1'b1;
        req = 4'b1111;
        tick("en");
        check("en_on.gnt", gnt, 4'b1000);

        // Reset in the middle of a grant, then fresh priority order.
        tick("midrst");
        do_reset();
        req = 4'b1111;
        tick("midrst");
        check("after_rst.gnt", gnt, 4'b0001);

        // Random traffic: persistent requests, occasional enable drops and resets.
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (req[b]) begin
                    if ($urandom_range(0, 99) < 15) req[b] = 1'b0;
                end else begin
                    if ($urandom_range(0, 99) < 25) req[b] = 1'b1;
                end
            end
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                tick("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
